clk_gate_ctrl: RTL and testbench

//  Controller that drives CLK_EN of the gated-clock cell (latch + AND) feeding a shared gated block, e.g. the ALU.

---
 rtl/clk_gate_ctrl.sv | 139 +++++++++++++
 tb/tb_clk_gate_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a shared gated block: wakes the gated clock on demand,
// grants the block round-robin, and gates the clock off after an idle hysteresis window.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               FORCE_ON,
  output logic               GATE_EN,
  output logic [NUM_REQ-1:0] GRANT,
  output logic               BUSY
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               on_q;

  logic               demand;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PTR_W-1:0]   ptr_nxt;

  assign demand = (|REQ) | FORCE_ON;

  // First active request at or after ptr_q, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    logic [PTR_W:0] sum;
    logic [PTR_W-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!pick_vld && REQ[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    pick_oh = pick_vld ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx) : '0;
    ptr_nxt = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      S_OFF: begin
        if (demand) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (demand) begin
          state_d = S_ON;
        end else begin
          state_d = S_IDLE;
          cnt_d   = IDLE_LOAD;
        end
      end
      S_ON: begin
        // A release only clears GRANT; the next owner is picked on a later edge.
        if (grant_q == '0) begin
          if (pick_vld) begin
            grant_d = pick_oh;
            ptr_d   = ptr_nxt;
          end else if (!demand) begin
            state_d = S_IDLE;
            cnt_d   = IDLE_LOAD;
          end
        end else if ((grant_q & REQ) == '0) begin
          grant_d = '0;
        end
      end
      S_IDLE: begin
        if (demand) begin
          state_d = S_ON;
        end else if (cnt_q == '0) begin
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  // GATE_EN/BUSY come straight from a flop so CLK_EN only moves after a rising edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      on_q    <= (state_d != S_OFF);
    end
  end

  assign GATE_EN = on_q;
  assign BUSY    = on_q;
  assign GRANT   = grant_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a timer/owner-based reference model.
module tb_clk_gate_ctrl;

  localparam int NR = 2;
  localparam int WK = 2;
  localparam int ID = 4;

  logic          CLK;
  logic          RST;
  logic [NR-1:0] REQ;
  logic          FORCE_ON;
  logic          GATE_EN;
  logic [NR-1:0] GRANT;
  logic          BUSY;

  int checks = 0;
  int errors = 0;

  clk_gate_ctrl #(
    .NUM_REQ(NR),
    .WAKE_CYCLES(WK),
    .IDLE_CYCLES(ID),
    .CNT_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
    .FORCE_ON(FORCE_ON),
    .GATE_EN(GATE_EN),
    .GRANT(GRANT),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] req;
    logic       frc;
    logic       e_gate;
    logic [1:0] e_grant;
    logic       e_busy;
  } vec_t;

  vec_t tbl[20];

  // Reference model: gate on/off, remaining wake cycles, remaining idle cycles, owner index.
  bit m_on;
  int m_wake;
  int m_idle;
  int m_owner;
  int m_ptr;

  task automatic model_reset();
    m_on = 0; m_wake = 0; m_idle = 0; m_owner = -1; m_ptr = 0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic f);
    bit dmd;
    dmd = (r != 2'b00) || f;
    if (!m_on) begin
      if (dmd) begin m_on = 1; m_wake = WK; end
    end else if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0 && !dmd) m_idle = ID;
    end else if (m_idle > 0) begin
      if (dmd) m_idle = 0;
      else begin
        m_idle--;
        if (m_idle == 0) m_on = 0;
      end
    end else if (m_owner < 0) begin
      if (r != 2'b00) begin
        for (int k = 0; k < NR; k++) begin
          int c;
          c = (m_ptr + k) % NR;
          if (m_owner < 0 && r[c]) m_owner = c;
        end
        m_ptr = (m_owner + 1) % NR;
      end else if (!f) begin
        m_idle = ID;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end
  endtask

  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    g = 2'b00;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string name, input logic e_gate, input logic [1:0] e_grant,
                     input logic e_busy);
    checks++;
    if (GATE_EN !== e_gate || GRANT !== e_grant || BUSY !== e_busy) begin
      errors++;
      $display("FAIL %s @%0t: got gate=%b grant=%b busy=%b, expected gate=%b grant=%b busy=%b",
               name, $time, GATE_EN, GRANT, BUSY, e_gate, e_grant, e_busy);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic f);
    REQ = r;
    FORCE_ON = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic step_chk(input string name, input logic [1:0] r, input logic f,
                          input logic e_gate, input logic [1:0] e_grant, input logic e_busy);
    step(r, f);
    chk(name, e_gate, e_grant, e_busy);
  endtask

  task automatic async_reset();
    RST = 1'b0;
    #1;
    RST = 1'b1;
  endtask

  initial begin
    logic [1:0] rr;
    logic       ff;

    // req, force, gate, grant, busy (expected after the edge)
    tbl[0]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[2]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[3]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[4]  = '{2'b01, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl[5]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl[6]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl[7]  = '{2'b10, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[8]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1};
    tbl[9]  = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1};
    tbl[10] = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1};
    tbl[11] = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[12] = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl[13] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[14] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[15] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[16] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[17] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b1};
    tbl[18] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[19] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0};

    // Reset held with requests pending
    RST = 1'b0;
    REQ = 2'b11;
    FORCE_ON = 1'b0;
    #1;
    chk("reset_async", 1'b0, 2'b00, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_held", 1'b0, 2'b00, 1'b0);
    RST = 1'b1;
    step_chk("reset_release_wake", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);

    // Table: wake latency, round robin with dead cycles, idle hysteresis
    async_reset();
    chk("reset_mid", 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++)
      step_chk($sformatf("tbl[%0d]", i), tbl[i].req, tbl[i].frc,
               tbl[i].e_gate, tbl[i].e_grant, tbl[i].e_busy);

    // Request returns during IDLE_WAIT: back to ON without a wake period
    step_chk("rw_wake0", 2'b10, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_wake1", 2'b10, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_on", 2'b10, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_grant", 2'b10, 1'b0, 1'b1, 2'b10, 1'b1);
    step_chk("rw_release", 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_idle1", 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_idle2", 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_back_on", 2'b01, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("rw_regrant", 2'b01, 1'b0, 1'b1, 2'b01, 1'b1);

    // FORCE_ON keeps the clock on without granting
    step_chk("force_release", 2'b00, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 50; i++)
      step_chk("force_hold", 2'b00, 1'b1, 1'b1, 2'b00, 1'b1);
    for (int i = 0; i < ID; i++)
      step_chk("force_off_idle", 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("force_off_gated", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

    // Async reset while requester 1 owns the block, then rr_ptr restarts at 0
    step_chk("ar_wake0", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("ar_wake1", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("ar_on", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("ar_grant10", 2'b11, 1'b0, 1'b1, 2'b10, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("ar_cleared", 1'b0, 2'b00, 1'b0);
    #1;
    RST = 1'b1;
    step_chk("ar_post_wake0", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("ar_post_wake1", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("ar_post_on", 2'b11, 1'b0, 1'b1, 2'b00, 1'b1);
    step_chk("ar_post_grant01", 2'b11, 1'b0, 1'b1, 2'b01, 1'b1);

    // Randomized traffic against the reference model
    async_reset();
    model_reset();
    rr = 2'b00;
    ff = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      if (ff) ff = ($urandom_range(0, 7) != 0);
      else    ff = ($urandom_range(0, 39) == 0);
      model_step(rr, ff);
      step(rr, ff);
      chk("rand", m_on, model_grant(), m_on);
      checks++;
      if ((GRANT & (GRANT - 2'b01)) != 2'b00) begin
        errors++;
        $display("FAIL rand_onehot @%0t: grant=%b, required one-hot or zero", $time, GRANT);
      end
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        model_reset();
        chk("rand_reset", 1'b0, 2'b00, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
